// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, stall buffering, branch delay slot and exception redirect
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        redirect_d,
  input  logic [31:0] redirect_pc_d,
  input  logic        exc_redirect,
  input  logic [31:0] exc_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_rdata,
  input  logic        inst_ok,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic        adel_d
);
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
  state_t      state;
  logic [31:0] pc_f, hold_buf, pend_pc, next_pc;
  logic        pend_v, mis, accept, advance, busy;
  assign mis        = pc_f[1:0] != 2'b00;
  assign inst_req   = state == FETCH && !mis;
  assign inst_addr  = pc_f;
  assign pc_plus4_d = pc_d + 32'd4;
  assign accept     = redirect_d && valid_d && !stallD;
  assign advance    = !stallD && (state == HOLD || (state == FETCH && (mis || inst_ok)));
  assign next_pc    = accept ? redirect_pc_d : pend_v ? pend_pc : pc_f + 32'd4;
  // a memory response is still owed to us; it must be swallowed after an exception
  assign busy       = !inst_ok && (inst_req || state == DISCARD);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc_f     <= 32'hBFC0_0000;
      pend_v   <= 1'b0;
      pend_pc  <= 32'd0;
      hold_buf <= 32'd0;
      pc_d     <= 32'd0;
      instr_d  <= 32'd0;
      valid_d  <= 1'b0;
      adel_d   <= 1'b0;
    end else if (exc_redirect) begin
      pc_f    <= exc_pc;
      pend_v  <= 1'b0;
      state   <= busy ? DISCARD : FETCH;
      instr_d <= 32'd0;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else begin
      if (advance) begin
        pc_f   <= next_pc;
        pend_v <= 1'b0;
      end else if (accept) begin
        pend_v  <= 1'b1;
        pend_pc <= redirect_pc_d;
      end
      if (state == FETCH && inst_ok && !mis && stallD) begin
        hold_buf <= inst_rdata;
        state    <= HOLD;
      end else if ((state == HOLD && !stallD) || (state == DISCARD && inst_ok))
        state <= FETCH;
      if (flushD || (!stallD && !advance)) begin
        instr_d <= 32'd0;
        valid_d <= 1'b0;
        adel_d  <= 1'b0;
      end else if (advance) begin
        pc_d    <= pc_f;
        instr_d <= state == HOLD ? hold_buf : mis ? 32'd0 : inst_rdata;
        valid_d <= 1'b1;
        adel_d  <= state == FETCH && mis;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with a latency-programmable memory model and scripted decode events
module tb_fetch_stage;
  logic        clk = 1'b0, rst, stallD, flushD, redirect_d, exc_redirect, inst_ok;
  logic        inst_req, valid_d, adel_d;
  logic [31:0] redirect_pc_d, exc_pc, inst_rdata, inst_addr, pc_d, pc_plus4_d, instr_d;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ins; logic adel;} exp_t;
  exp_t q[$];
  logic [31:0] br_pc, br_tgt, slow_addr, stall_pc, flush_pc, exc_addr, oaddr;
  int  slow_lat, cnt, lat_o, stall_cnt, pend_cnt;
  bit  br_en, stall_en, flush_en, exc_en, out_v, stall_done, flush_done, exc_done, prev_st, prev_ex;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD), .redirect_d(redirect_d),
    .redirect_pc_d(redirect_pc_d), .exc_redirect(exc_redirect), .exc_pc(exc_pc),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .instr_d(instr_d), .valid_d(valid_d), .adel_d(adel_d)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(logic [31:0] pc, bit adel);
    q.push_back('{pc, adel ? 32'h0 : pc, adel});
  endtask

  task automatic knobs_clear();
    br_en = 0; stall_en = 0; flush_en = 0; exc_en = 0;
    br_pc = 0; br_tgt = 0; stall_pc = 0; flush_pc = 0; exc_addr = 0;
    slow_addr = 32'hFFFF_FFFF; slow_lat = 0;
  endtask

  task automatic do_reset();
    rst = 1; stallD = 0; flushD = 0; redirect_d = 0; redirect_pc_d = 0;
    exc_redirect = 0; exc_pc = 0; inst_ok = 1; inst_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_valid_d", {31'b0, valid_d}, 32'h0);
    chk("rst_adel_d", {31'b0, adel_d}, 32'h0);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    chk("rst_req", {31'b0, inst_req}, 32'h1);
    rst = 0; inst_ok = 0;
    out_v = 0; cnt = 0; q.delete(); pend_cnt = 0; stall_cnt = 0;
    stall_done = 0; flush_done = 0; exc_done = 0; prev_st = 0; prev_ex = 0;
  endtask

  task automatic cyc();
    bit st, fl, ex;
    exp_t e;
    redirect_d    = br_en && valid_d && pc_d == br_pc;
    redirect_pc_d = br_tgt;
    if (stall_en && !stall_done && valid_d && pc_d == stall_pc) begin
      stall_cnt = 2; stall_done = 1;
    end
    fl = flush_en && !flush_done && valid_d && pc_d == flush_pc;
    if (fl) flush_done = 1;
    st = fl || stall_cnt > 0;
    if (stall_cnt == 1) chk("hold_req", {31'b0, inst_req}, 32'h0);
    if (stall_cnt > 0) stall_cnt--;
    ex = exc_en && !exc_done && inst_req && inst_addr == exc_addr;
    if (ex) exc_done = 1;
    if (prev_ex) begin
      chk("disc_req", {31'b0, inst_req}, 32'h0);
      chk("exc_addr", inst_addr, 32'hBFC0_0380);
    end
    stallD = st; flushD = fl; exc_redirect = ex; exc_pc = 32'hBFC0_0380;
    if (inst_req) chk("req_align", {30'b0, inst_addr[1:0]}, 32'h0);
    if (out_v) begin
      if (inst_req) chk("addr_stable", inst_addr, oaddr);
      inst_ok = cnt >= lat_o; inst_rdata = oaddr;
    end else if (inst_req) begin
      oaddr = inst_addr; lat_o = inst_addr == slow_addr ? slow_lat : 0; cnt = 0;
      inst_ok = lat_o == 0; inst_rdata = inst_addr; out_v = !inst_ok;
    end else begin
      inst_ok = 0; inst_rdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    if (inst_ok) out_v = 0;
    else if (out_v) cnt++;
    pend_cnt += int'(dut.pend_v);
    if (fl) chk("flush_bubble", {31'b0, valid_d}, 32'h0);
    if (stall_en && prev_st && !st) chk("hold_load", pc_d, stall_pc + 32'd4);
    if (!st && !ex && valid_d) begin
      if (q.size() == 0) chk("extra_valid", {31'b0, valid_d}, 32'h0);
      else begin
        e = q.pop_front();
        chk("pc_d", pc_d, e.pc);
        chk("instr_d", instr_d, e.ins);
        chk("adel_d", {31'b0, adel_d}, {31'b0, e.adel});
        chk("pc_plus4_d", pc_plus4_d, e.pc + 32'd4);
      end
    end
    prev_st = st; prev_ex = ex;
  endtask

  task automatic run(int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      cyc();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic push_seq(logic [31:0] first, int n);
    for (int i = 0; i < n; i++) push(first + 32'(4 * i), 0);
  endtask

  initial begin
    // reset while a slow request is outstanding
    knobs_clear(); slow_addr = 32'hBFC0_0000; slow_lat = 3;
    do_reset(); cyc(); cyc();
    knobs_clear(); do_reset();
    push_seq(32'hBFC0_0000, 3); run(50);
    // taken branch with delay slot
    knobs_clear(); br_en = 1; br_pc = 32'hBFC0_0010; br_tgt = 32'hBFC0_0100;
    do_reset(); push_seq(32'hBFC0_0000, 6); push_seq(32'hBFC0_0100, 2); run(80);
    // same branch, slow delay-slot fetch leaves the redirect pending
    slow_addr = 32'hBFC0_0014; slow_lat = 2;
    do_reset(); push_seq(32'hBFC0_0000, 6); push_seq(32'hBFC0_0100, 2); run(80);
    chk("pend_cycles", pend_cnt, 2);
    // stall while a word returns
    knobs_clear(); stall_en = 1; stall_pc = 32'hBFC0_0008;
    do_reset(); push_seq(32'hBFC0_0000, 5); run(80);
    // exception with a request in flight
    knobs_clear(); exc_en = 1; exc_addr = 32'hBFC0_0008; slow_addr = 32'hBFC0_0008; slow_lat = 2;
    do_reset(); push_seq(32'hBFC0_0000, 2); push_seq(32'hBFC0_0380, 2); run(80);
    // jump to a misaligned target
    knobs_clear(); br_en = 1; br_pc = 32'hBFC0_0010; br_tgt = 32'hBFC0_0102;
    do_reset(); push_seq(32'hBFC0_0000, 6); push(32'hBFC0_0102, 1); push(32'hBFC0_0106, 1); run(80);
    // flush together with stall
    knobs_clear(); flush_en = 1; flush_pc = 32'hBFC0_0004;
    do_reset(); push_seq(32'hBFC0_0000, 4); run(80);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stallD  in  1  decode stage stalled; IF/ID register holds.
REQ-004 flushD  in  1  clear IF/ID to bubble at next edge.
REQ-005 redirect_d  in  1  branch taken (comparator result gated by branch op) or jump, for the instruction in decode.
REQ-006 redirect_pc_d  in  32  branch/jump target.
REQ-007 exc_redirect  in  1  exception/eret redirect, highest priority.
REQ-008 exc_pc  in  32  exception target PC.
REQ-009 inst_req  out  1  instruction memory request.
REQ-010 inst_addr  out  32  request address, equal to pc_f.
REQ-011 inst_rdata  in  32  fetched word, valid when inst_ok=1.
REQ-012 inst_ok  in  1  one-cycle completion pulse; latency of 1 or more cycles after request.
REQ-013 pc_d  out  32  IF/ID PC.
REQ-014 pc_plus4_d  out  32  pc_d+4.
REQ-015 instr_d  out  32  IF/ID instruction.
REQ-016 valid_d  out  1  IF/ID holds a real instruction.
REQ-017 adel_d  out  1  IF/ID instruction had a misaligned fetch address.

Function
REQ-018 States SHALL be FETCH, HOLD and DISCARD; the internal PC SHALL be pc_f, with a 32-bit hold buffer and a pending redirect register (pend_v, pend_pc).
REQ-019 FETCH: inst_req=1 when pc_f[1:0]==0; on inst_ok with stallD=0, load IF/ID {pc_f, inst_rdata, valid=1, adel=0}, set pc_f<=next_pc, and stay in FETCH.
REQ-020 FETCH, inst_ok and stallD=1: capture inst_rdata into the buffer; go to HOLD; pc_f unchanged.
REQ-021 FETCH, no inst_ok, stallD=0: load an IF/ID bubble (valid_d=0, instr_d=0); pc_f unchanged.
REQ-022 HOLD: inst_req=0; when stallD=0, load the buffer into IF/ID, set pc_f<=next_pc, and go to FETCH.
REQ-023 next_pc SHALL be, in priority order: redirect_pc_d if a redirect is accepted this cycle; else pend_pc if pend_v; else pc_f+4 (32-bit wrap).
REQ-024 A redirect is accepted when redirect_d, valid_d and !stallD are all 1; if pc_f does not advance in the same cycle, set pend_v<=1 and pend_pc<=redirect_pc_d.
REQ-025 pend_v SHALL clear when pc_f advances.
REQ-026 This yields exactly one delay-slot instruction (the word at branch PC+4), which SHALL never be flushed by a redirect.
REQ-027 Misaligned pc_f[1:0]!=0 in FETCH: no request; when stallD=0, load IF/ID {pc_f, 0, valid=1, adel=1} and advance pc_f as in REQ-019.
REQ-028 exc_redirect SHALL override everything: pc_f<=exc_pc, pend_v<=0, IF/ID bubble; if a request is outstanding (FETCH with no inst_ok), go to DISCARD, otherwise go to FETCH.
REQ-029 DISCARD: inst_req=0; drop data on inst_ok and go to FETCH at pc_f.
REQ-030 flushD SHALL force an IF/ID bubble regardless of stallD; state and pc_f follow the normal rules.
REQ-031 pc_plus4_d SHALL be computed combinationally from pc_d.
REQ-032 The request address SHALL be held stable while inst_req=1 until inst_ok.

Reset
REQ-033 rst SHALL set pc_f=32'hBFC0_0000, state=FETCH, pend_v=0, pend_pc=0, buffer=0, pc_d=0, instr_d=0, valid_d=0, adel_d=0.
REQ-034 rst SHALL override all other inputs, including in the middle of an outstanding request.
REQ-035 An inst_ok arriving in the first cycle after reset SHALL be ignored only if no request was issued.

Verification
REQ-036 Release reset; inst_ok every cycle with data = address -> instr_d sequence BFC00000, BFC00004, BFC00008, valid_d=1.
REQ-037 Branch at 0xBFC00010 in decode with redirect_d=1 and target 0xBFC00100 -> IF/ID receives 0xBFC00014 (delay slot), then 0xBFC00100.
REQ-038 Same branch with 3-cycle memory latency on the delay-slot fetch -> pend_v=1 for 2 cycles; next request address 0xBFC00100; bubbles in between.
REQ-039 inst_ok while stallD=1 for 2 cycles -> state HOLD, inst_req=0; IF/ID loads the buffered word in the cycle stallD falls.
REQ-040 exc_redirect to 0xBFC00380 with a request outstanding -> state DISCARD; the late inst_ok data is dropped; the next request address is 0xBFC00380.
REQ-041 Jump to 0xBFC00102 -> adel_d=1, instr_d=0, valid_d=1, and no inst_req for that address.
